// File: rtl/ems_sram_controller.sv
// ----------------------------------------------------------------------------
// ems_sram_controller
//
// Sits between the chipset bus arbiter and an external byte-wide SRAM.
// Conventional RAM (00000-9FFFF) maps straight through to the lower 1 MB of
// the SRAM. A 64 KB EMS page frame made of four 16 KB windows maps into the
// upper 1 MB through four IO-mapped page registers. Each memory access is
// paced by a small FSM that holds the bus not-ready until the SRAM cycle has
// finished.
//
// Ports
//   clock                 system clock, single domain
//   reset_n               asynchronous active-low reset
//   address               latched system address (20 bits)
//   data_bus_in           write data from the internal data bus
//   memory_read_n/_write_n   memory strobes, active low
//   io_read_n/io_write_n     IO strobes, active low
//   ems_enabled           1 = EMS frame and page ports decoded
//   ems_address           frame base: 00=C0000 01=D0000 10=E0000 11=off
//   ram_address_select_n  low while the address hits RAM or an enabled window
//   ram_data_out          registered SRAM read data / page-register readback
//   ram_data_valid        1 when ram_data_out must be muxed onto the bus
//   ram_ready             0 = insert wait states
//   sram_addr             SRAM address (21 bits)
//   sram_data_out         SRAM write data
//   sram_data_oe          1 = drive the SRAM data pins
//   sram_data_in          SRAM read data
//   sram_we_n             SRAM write enable, active low
// ----------------------------------------------------------------------------
module ems_sram_controller #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [9:0]  EMS_IO_BASE = 10'h260
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [19:0] address,
    input  logic [7:0]  data_bus_in,
    input  logic        memory_read_n,
    input  logic        memory_write_n,
    input  logic        io_read_n,
    input  logic        io_write_n,
    input  logic        ems_enabled,
    input  logic [1:0]  ems_address,
    output logic        ram_address_select_n,
    output logic [7:0]  ram_data_out,
    output logic        ram_data_valid,
    output logic        ram_ready,
    output logic [20:0] sram_addr,
    output logic [7:0]  sram_data_out,
    output logic        sram_data_oe,
    input  logic [7:0]  sram_data_in,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t      state_q;
    logic        isWrite_q;
    logic [2:0]  waitCnt_q;

    logic        memRdPrev_q;
    logic        memWrPrev_q;
    logic        ioWrPrev_q;

    logic [3:0]  ena_q;
    logic [5:0]  page_q [4];

    logic [20:0] sramAddr_q;
    logic [7:0]  sramDataOut_q;
    logic        sramDataOe_q;
    logic        sramWeN_q;
    logic        ramReady_q;
    logic [7:0]  ramDataOut_q;
    logic        ramDataValid_q;

    logic        ramHit;
    logic        emsHit;
    logic        memHit;
    logic [3:0]  frameBase;
    logic [20:0] mappedAddr;
    logic [9:0]  ioOffset;
    logic        ioSel;
    logic [1:0]  ioIdx;
    logic [7:0]  pageReadback;
    logic        rdEdge;
    logic        wrEdge;
    logic        ioWrEdge;
    logic        ioRdActive;

    // Address decode and EMS window translation. The frame base nibble is
    // C, D or E, which is simply 2'b11 followed by ems_address.
    always_comb begin
        frameBase    = {2'b11, ems_address};
        ramHit       = (address < 20'hA0000);
        emsHit       = ems_enabled && (ems_address != 2'b11) &&
                       (address[19:16] == frameBase) && ena_q[address[15:14]];
        memHit       = ramHit || emsHit;
        mappedAddr   = emsHit ? {1'b1, page_q[address[15:14]], address[13:0]}
                              : {1'b0, address};
        ioOffset     = address[9:0] - EMS_IO_BASE;
        ioSel        = ems_enabled && (ioOffset < 10'd4);
        ioIdx        = address[1:0];
        pageReadback = {ena_q[ioIdx], 1'b0, page_q[ioIdx]};
        rdEdge       = memRdPrev_q && !memory_read_n;
        wrEdge       = memWrPrev_q && !memory_write_n;
        ioWrEdge     = ioWrPrev_q && !io_write_n && ioSel;
        ioRdActive   = !io_read_n && ioSel;
    end

    // Strobe history for edge detection, and the page registers. Page writes
    // are accepted in any FSM state; because sram_addr is captured when an
    // access starts, a mid-access page change only affects later accesses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            memRdPrev_q <= 1'b1;
            memWrPrev_q <= 1'b1;
            ioWrPrev_q  <= 1'b1;
            ena_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                page_q[i] <= '0;
            end
        end else begin
            memRdPrev_q <= memory_read_n;
            memWrPrev_q <= memory_write_n;
            ioWrPrev_q  <= io_write_n;
            if (ioWrEdge) begin
                ena_q[ioIdx]  <= data_bus_in[7];
                page_q[ioIdx] <= data_bus_in[5:0];
            end
        end
    end

    // Access sequencer. Simultaneous read and write edges are treated as a
    // read so the SRAM is never written by an ambiguous cycle. ram_ready is
    // released on the first DONE clock, giving WAIT_STATES+2 not-ready clocks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            isWrite_q      <= 1'b0;
            waitCnt_q      <= '0;
            sramAddr_q     <= '0;
            sramDataOut_q  <= '0;
            sramDataOe_q   <= 1'b0;
            sramWeN_q      <= 1'b1;
            ramReady_q     <= 1'b1;
            ramDataOut_q   <= '0;
            ramDataValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ramReady_q     <= 1'b1;
                    ramDataValid_q <= ioRdActive;
                    if (ioRdActive) begin
                        ramDataOut_q <= pageReadback;
                    end
                    if ((rdEdge || wrEdge) && memHit) begin
                        state_q    <= SETUP;
                        ramReady_q <= 1'b0;
                        isWrite_q  <= wrEdge && !rdEdge;
                        sramAddr_q <= mappedAddr;
                        if (wrEdge && !rdEdge) begin
                            sramDataOut_q <= data_bus_in;
                            sramDataOe_q  <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    waitCnt_q <= 3'(WAIT_STATES - 1);
                    sramWeN_q <= !isWrite_q;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (waitCnt_q == 3'd0) begin
                        sramWeN_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        waitCnt_q <= waitCnt_q - 3'd1;
                    end
                end
                DONE: begin
                    // First DONE clock completes the access; afterwards wait
                    // for the bus to release both memory strobes.
                    if (!ramReady_q) begin
                        ramReady_q   <= 1'b1;
                        sramDataOe_q <= 1'b0;
                        if (!isWrite_q) begin
                            ramDataOut_q   <= sram_data_in;
                            ramDataValid_q <= 1'b1;
                        end
                    end else if (memory_read_n && memory_write_n) begin
                        state_q        <= IDLE;
                        ramDataValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ram_address_select_n = !memHit;
    assign ram_data_out         = ramDataOut_q;
    assign ram_data_valid       = ramDataValid_q;
    assign ram_ready            = ramReady_q;
    assign sram_addr            = sramAddr_q;
    assign sram_data_out        = sramDataOut_q;
    assign sram_data_oe         = sramDataOe_q;
    assign sram_we_n            = sramWeN_q;

endmodule

// File: tb/tb_ems_sram_controller.sv
// ----------------------------------------------------------------------------
// tb_ems_sram_controller
//
// Directed bench for ems_sram_controller with WAIT_STATES=2. A behavioural
// SRAM sits on the controller's SRAM pins so writes can be read back.
// ----------------------------------------------------------------------------
module tb_ems_sram_controller;

    logic        clock;
    logic        reset_n;
    logic [19:0] address;
    logic [7:0]  data_bus_in;
    logic        memory_read_n;
    logic        memory_write_n;
    logic        io_read_n;
    logic        io_write_n;
    logic        ems_enabled;
    logic [1:0]  ems_address;
    logic        ram_address_select_n;
    logic [7:0]  ram_data_out;
    logic        ram_data_valid;
    logic        ram_ready;
    logic [20:0] sram_addr;
    logic [7:0]  sram_data_out;
    logic        sram_data_oe;
    logic [7:0]  sram_data_in;
    logic        sram_we_n;

    int passCount  = 0;
    int checkCount = 0;

    int          readyLow;
    int          weLow;
    logic [20:0] seenAddr;
    logic [7:0]  seenData;
    logic        seenOe;

    logic [7:0]  sramMem [0:(1 << 21) - 1];

    ems_sram_controller #(
        .WAIT_STATES (2),
        .EMS_IO_BASE (10'h260)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .address              (address),
        .data_bus_in          (data_bus_in),
        .memory_read_n        (memory_read_n),
        .memory_write_n       (memory_write_n),
        .io_read_n            (io_read_n),
        .io_write_n           (io_write_n),
        .ems_enabled          (ems_enabled),
        .ems_address          (ems_address),
        .ram_address_select_n (ram_address_select_n),
        .ram_data_out         (ram_data_out),
        .ram_data_valid       (ram_data_valid),
        .ram_ready            (ram_ready),
        .sram_addr            (sram_addr),
        .sram_data_out        (sram_data_out),
        .sram_data_oe         (sram_data_oe),
        .sram_data_in         (sram_data_in),
        .sram_we_n            (sram_we_n)
    );

    // Free-running 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural SRAM: write while WE_n is low, asynchronous read
    always @(posedge clock) begin
        if (!sram_we_n) begin
            sramMem[sram_addr] <= sram_data_out;
        end
    end
    assign sram_data_in = sramMem[sram_addr];

    // Overall time bound so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [19:0] addr, input logic [7:0] data,
                                 input logic mr, input logic mw,
                                 input logic ir, input logic iw);
        address        = addr;
        data_bus_in    = data;
        memory_read_n  = mr;
        memory_write_n = mw;
        io_read_n      = ir;
        io_write_n     = iw;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Step until ram_ready returns (bounded), counting not-ready and WE_n low
    // clocks; optionally drop the memory strobes after the first clock.
    task automatic runAccess(input bit releaseEarly);
        readyLow = 0;
        weLow    = 0;
        seenAddr = '0;
        seenData = '0;
        seenOe   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stepClock();
            if (!sram_we_n) begin
                weLow++;
                seenAddr = sram_addr;
                seenData = sram_data_out;
                seenOe   = sram_data_oe;
            end
            if (ram_ready) break;
            readyLow++;
            if (releaseEarly && i == 0) begin
                memory_read_n  = 1'b1;
                memory_write_n = 1'b1;
            end
        end
    endtask

    task automatic ioWrite(input logic [19:0] addr, input logic [7:0] data);
        applyStimulus(addr, data, 1'b1, 1'b1, 1'b1, 1'b0);
        stepClock();
        applyStimulus(addr, data, 1'b1, 1'b1, 1'b1, 1'b1);
        stepClock();
    endtask

    task automatic releaseBus();
        applyStimulus(address, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        stepClock();
    endtask

    initial begin
        reset_n     = 1'b0;
        ems_enabled = 1'b1;
        ems_address = 2'b01;
        applyStimulus(20'h00000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);

        // Reset state
        stepClock();
        stepClock();
        checkOutput("reset_ready", 32'(ram_ready), 32'h1);
        checkOutput("reset_we_n", 32'(sram_we_n), 32'h1);
        checkOutput("reset_oe", 32'(sram_data_oe), 32'h0);
        checkOutput("reset_valid", 32'(ram_data_valid), 32'h0);
        checkOutput("reset_data_out", 32'(ram_data_out), 32'h0);
        checkOutput("reset_sram_addr", 32'(sram_addr), 32'h0);
        reset_n = 1'b1;
        stepClock();

        // Test 1: conventional RAM write of 0x5A to 0x12345
        $display("[TB] test 1: RAM write");
        applyStimulus(20'h12345, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("t1_select_n", 32'(ram_address_select_n), 32'h0);
        runAccess(1'b0);
        checkOutput("t1_ready_low_clocks", 32'(readyLow), 32'd4);
        checkOutput("t1_we_low_clocks", 32'(weLow), 32'd2);
        checkOutput("t1_sram_addr", 32'(seenAddr), 32'h012345);
        checkOutput("t1_sram_data", 32'(seenData), 32'h5A);
        checkOutput("t1_oe_during_we", 32'(seenOe), 32'h1);
        checkOutput("t1_oe_after_done", 32'(sram_data_oe), 32'h0);
        releaseBus();
        stepClock();
        applyStimulus(20'h12345, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        runAccess(1'b0);
        checkOutput("t1_readback", 32'(ram_data_out), 32'h5A);
        releaseBus();

        // Test 2: page register 1 = 0x85, then EMS write/read at D4001
        $display("[TB] test 2: EMS window access");
        ioWrite(20'h00261, 8'h85);
        applyStimulus(20'hD4001, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("t2_select_n", 32'(ram_address_select_n), 32'h0);
        runAccess(1'b0);
        checkOutput("t2_write_addr", 32'(seenAddr), 32'h114001);
        checkOutput("t2_write_we_clocks", 32'(weLow), 32'd2);
        releaseBus();
        stepClock();
        applyStimulus(20'hD4001, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        runAccess(1'b0);
        checkOutput("t2_read_ready_low", 32'(readyLow), 32'd4);
        checkOutput("t2_read_we_clocks", 32'(weLow), 32'd0);
        checkOutput("t2_read_addr", 32'(sram_addr), 32'h114001);
        checkOutput("t2_read_data", 32'(ram_data_out), 32'hC3);
        checkOutput("t2_read_valid", 32'(ram_data_valid), 32'h1);
        releaseBus();
        checkOutput("t2_valid_cleared", 32'(ram_data_valid), 32'h0);

        // Test 3: page register readback, and no decode with EMS disabled
        $display("[TB] test 3: page register readback");
        applyStimulus(20'h00261, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        stepClock();
        checkOutput("t3_readback_data", 32'(ram_data_out), 32'h85);
        checkOutput("t3_readback_valid", 32'(ram_data_valid), 32'h1);
        releaseBus();
        checkOutput("t3_valid_released", 32'(ram_data_valid), 32'h0);
        ems_enabled = 1'b0;
        ioWrite(20'h00261, 8'h00);
        applyStimulus(20'h00261, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        stepClock();
        checkOutput("t3_disabled_valid", 32'(ram_data_valid), 32'h0);
        releaseBus();
        ems_enabled = 1'b1;
        applyStimulus(20'h00261, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        stepClock();
        checkOutput("t3_disabled_write_ignored", 32'(ram_data_out), 32'h85);
        releaseBus();

        // Test 4: unmapped accesses produce no cycle
        $display("[TB] test 4: unmapped addresses");
        applyStimulus(20'hB8000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("t4_b8000_select_n", 32'(ram_address_select_n), 32'h1);
        runAccess(1'b0);
        checkOutput("t4_b8000_ready_low", 32'(readyLow), 32'd0);
        checkOutput("t4_b8000_we_clocks", 32'(weLow), 32'd0);
        releaseBus();
        ioWrite(20'h00261, 8'h05);
        applyStimulus(20'hD4001, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("t4_ena0_select_n", 32'(ram_address_select_n), 32'h1);
        runAccess(1'b0);
        checkOutput("t4_ena0_ready_low", 32'(readyLow), 32'd0);
        releaseBus();
        ioWrite(20'h00261, 8'h85);
        ems_address = 2'b11;
        applyStimulus(20'hD4001, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("t4_frame_off_select_n", 32'(ram_address_select_n), 32'h1);
        ems_address = 2'b01;
        #1;
        checkOutput("t4_frame_on_select_n", 32'(ram_address_select_n), 32'h0);

        // Test 5: asynchronous reset during the ACCESS phase of a write
        $display("[TB] test 5: reset mid-access");
        applyStimulus(20'h00100, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1);
        stepClock();
        stepClock();
        checkOutput("t5_we_low_before_reset", 32'(sram_we_n), 32'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("t5_we_n_async", 32'(sram_we_n), 32'h1);
        checkOutput("t5_oe_async", 32'(sram_data_oe), 32'h0);
        checkOutput("t5_ready_async", 32'(ram_ready), 32'h1);
        applyStimulus(20'h00100, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        stepClock();
        checkOutput("t5_we_n_held", 32'(sram_we_n), 32'h1);
        reset_n = 1'b1;
        stepClock();
        applyStimulus(20'h00261, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        stepClock();
        checkOutput("t5_page_cleared", 32'(ram_data_out), 32'h00);
        checkOutput("t5_page_valid", 32'(ram_data_valid), 32'h1);
        releaseBus();
        applyStimulus(20'h00200, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        runAccess(1'b0);
        checkOutput("t5_next_ready_low", 32'(readyLow), 32'd4);
        checkOutput("t5_next_we_clocks", 32'(weLow), 32'd2);
        checkOutput("t5_next_addr", 32'(seenAddr), 32'h000200);
        releaseBus();

        // Test 6: write strobe released after one clock, then a same-clock
        // read/write collision that must behave as a read
        $display("[TB] test 6: early strobe release");
        stepClock();
        applyStimulus(20'h00300, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        runAccess(1'b1);
        checkOutput("t6_ready_low", 32'(readyLow), 32'd4);
        checkOutput("t6_we_clocks", 32'(weLow), 32'd2);
        checkOutput("t6_write_data", 32'(seenData), 32'hA5);
        stepClock();
        stepClock();
        applyStimulus(20'h00300, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
        runAccess(1'b0);
        checkOutput("t6_collision_ready_low", 32'(readyLow), 32'd4);
        checkOutput("t6_collision_we_clocks", 32'(weLow), 32'd0);
        checkOutput("t6_collision_read_data", 32'(ram_data_out), 32'hA5);
        checkOutput("t6_collision_valid", 32'(ram_data_valid), 32'h1);
        releaseBus();
        checkOutput("t6_valid_cleared", 32'(ram_data_valid), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
